// File: rtl/h_tube_ctrl.sv
// Host-side Tube register front end: address decode, read mux, control flags, IRQ/NMI.
// Latency: strobes combinational in the access cycle; h_dout, h_irq_b, h_nmi_b registered (1 cycle).
// Backpressure: none; every h_cs cycle is one access, pops on an empty FIFO are ignored by the FIFO.
//
// Ports:
//   h_phi2, h_rst            clock and asynchronous active-high reset
//   h_cs, h_addr, h_rdnw     host access strobe, 3-bit register address, read/not-write
//   h_din, h_dout            host write data, registered read data
//   ph_data                  parasite-to-host FIFO data (muxed by h_selectData)
//   ph_data_available        per-register data available, parasite-to-host
//   ph_zero_bytes_available  R3 parasite-to-host FIFO completely empty
//   hp_not_full              per-register space available, host-to-parasite
//   h_selectData             one-hot register select to the FIFO quads
//   h_rd, h_we, h_wdata      pop strobe, per-register push strobes, push data
//   one_byte_mode, p_rst     V and P flags
//   h_clr_fifos              FIFO clear pulse driven by the T flag
//   h_irq_b, h_nmi_b         active-low host interrupts
module h_tube_ctrl #(
  parameter int T_PULSE_LEN = 2
) (
  input  logic       h_phi2,
  input  logic       h_rst,
  input  logic       h_cs,
  input  logic [2:0] h_addr,
  input  logic       h_rdnw,
  input  logic [7:0] h_din,
  output logic [7:0] h_dout,
  input  logic [7:0] ph_data,
  input  logic [3:0] ph_data_available,
  input  logic       ph_zero_bytes_available,
  input  logic [3:0] hp_not_full,
  output logic [3:0] h_selectData,
  output logic       h_rd,
  output logic [3:0] h_we,
  output logic [7:0] h_wdata,
  output logic       one_byte_mode,
  output logic       p_rst,
  output logic       h_clr_fifos,
  output logic       h_irq_b,
  output logic       h_nmi_b
);

  // Counter wide enough to hold T_PULSE_LEN (at least one bit).
  localparam int CW = (T_PULSE_LEN < 2) ? 1 : $clog2(T_PULSE_LEN + 1);
  localparam logic [CW-1:0] T_LOAD = CW'(T_PULSE_LEN);
  localparam logic [CW-1:0] T_ONE  = CW'(1);
  localparam logic [CW-1:0] T_ZERO = '0;

  // Bit positions of the six stored flags; they match the h_din bit
  // positions of a control write, so set/clear is a plain mask operation.
  localparam int FLAG_P = 5;
  localparam int FLAG_V = 4;
  localparam int FLAG_M = 3;
  localparam int FLAG_J = 2;

  localparam int CTRL_SET_BIT = 7;
  localparam int CTRL_T_BIT   = 6;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [1:0] reg_n;
  logic [3:0] reg_onehot;
  logic       is_data;
  logic       rd_acc;
  logic       wr_acc;
  logic       ctrl_wr;

  assign reg_n      = h_addr[2:1];
  assign reg_onehot = 4'b0001 << reg_n;
  assign is_data    = h_addr[0];
  assign rd_acc     = h_cs & h_rdnw;
  assign wr_acc     = h_cs & ~h_rdnw;
  // Only address 0 carries the control register; other status addresses
  // are read-only and writes to them fall on the floor.
  assign ctrl_wr    = wr_acc & (h_addr == 3'd0);

  assign h_selectData = h_cs ? reg_onehot : 4'b0000;
  assign h_rd         = rd_acc & is_data;
  assign h_we         = (wr_acc & is_data) ? reg_onehot : 4'b0000;
  assign h_wdata      = h_din;

  // ---------------------------------------------------------------------------
  // Flags P V M J I Q and the T pulse counter
  // ---------------------------------------------------------------------------
  logic [5:0]    flags;
  logic [5:0]    flags_next;
  logic [CW-1:0] t_cnt;
  logic [CW-1:0] t_cnt_next;
  logic          t_active;

  // T has no storage of its own: it is "set" exactly while the clear pulse
  // is running, so auto-clear falls out of the counter reaching zero.
  assign t_active = (t_cnt != T_ZERO);

  always_comb begin
    flags_next = flags;
    if (ctrl_wr) begin
      if (h_din[CTRL_SET_BIT]) begin
        flags_next = flags | h_din[5:0];
      end else begin
        flags_next = flags & ~h_din[5:0];
      end
    end
  end

  // A T write overrides the countdown in the same cycle: set reloads,
  // clear zeroes, so a set that coincides with auto-clear still wins.
  always_comb begin
    t_cnt_next = t_active ? (t_cnt - T_ONE) : T_ZERO;
    if (ctrl_wr && h_din[CTRL_T_BIT]) begin
      t_cnt_next = h_din[CTRL_SET_BIT] ? T_LOAD : T_ZERO;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [5:0] status_flags;
  logic [7:0] status_byte;
  logic [7:0] read_byte;

  assign status_flags = (reg_n == 2'd0) ? flags : 6'b000000;
  assign status_byte  = {ph_data_available[reg_n], hp_not_full[reg_n], status_flags};
  // ph_data is sampled in the pop cycle, i.e. before the FIFO advances.
  assign read_byte    = is_data ? ph_data : status_byte;

  // ---------------------------------------------------------------------------
  // Interrupt sources
  // ---------------------------------------------------------------------------
  logic irq_next;
  logic nmi_src;
  logic nmi_next;

  assign irq_next = ~(flags[FLAG_J] & ph_data_available[3]);
  // In one-byte mode NMI wants a single byte in R3; otherwise it waits for
  // the FIFO to hold anything at all (not fully empty).
  assign nmi_src  = flags[FLAG_V] ? ph_data_available[2] : ~ph_zero_bytes_available;
  assign nmi_next = ~(flags[FLAG_M] & nmi_src);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      flags   <= 6'b000000;
      t_cnt   <= T_ZERO;
      h_dout  <= 8'h00;
      h_irq_b <= 1'b1;
      h_nmi_b <= 1'b1;
    end else begin
      flags   <= flags_next;
      t_cnt   <= t_cnt_next;
      if (rd_acc) begin
        h_dout <= read_byte;
      end
      h_irq_b <= irq_next;
      h_nmi_b <= nmi_next;
    end
  end

  assign one_byte_mode = flags[FLAG_V];
  assign p_rst         = flags[FLAG_P];
  assign h_clr_fifos   = t_active;

endmodule

// File: tb/tb_h_tube_ctrl.sv
module tb_h_tube_ctrl;

  localparam int T_LEN = 2;

  logic       h_phi2;
  logic       h_rst;
  logic       h_cs;
  logic [2:0] h_addr;
  logic       h_rdnw;
  logic [7:0] h_din;
  logic [7:0] h_dout;
  logic [7:0] ph_data;
  logic [3:0] ph_data_available;
  logic       ph_zero_bytes_available;
  logic [3:0] hp_not_full;
  logic [3:0] h_selectData;
  logic       h_rd;
  logic [3:0] h_we;
  logic [7:0] h_wdata;
  logic       one_byte_mode;
  logic       p_rst;
  logic       h_clr_fifos;
  logic       h_irq_b;
  logic       h_nmi_b;

  h_tube_ctrl #(.T_PULSE_LEN(T_LEN)) dut (
    .h_phi2                  (h_phi2),
    .h_rst                   (h_rst),
    .h_cs                    (h_cs),
    .h_addr                  (h_addr),
    .h_rdnw                  (h_rdnw),
    .h_din                   (h_din),
    .h_dout                  (h_dout),
    .ph_data                 (ph_data),
    .ph_data_available       (ph_data_available),
    .ph_zero_bytes_available (ph_zero_bytes_available),
    .hp_not_full             (hp_not_full),
    .h_selectData            (h_selectData),
    .h_rd                    (h_rd),
    .h_we                    (h_we),
    .h_wdata                 (h_wdata),
    .one_byte_mode           (one_byte_mode),
    .p_rst                   (p_rst),
    .h_clr_fifos             (h_clr_fifos),
    .h_irq_b                 (h_irq_b),
    .h_nmi_b                 (h_nmi_b)
  );

  initial h_phi2 = 1'b0;
  always #5 h_phi2 = ~h_phi2;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge h_phi2);
    #1;
  endtask

  task automatic acc(input logic [2:0] a, input logic rw, input logic [7:0] d);
    h_cs   = 1'b1;
    h_addr = a;
    h_rdnw = rw;
    h_din  = d;
    tick();
    h_cs = 1'b0;
  endtask

  typedef struct {
    logic       cs;
    logic [2:0] addr;
    logic       rdnw;
    logic [7:0] din;
    logic [7:0] pdata;
    logic [3:0] dav;
    logic [3:0] nf;
    logic [3:0] e_sel;
    logic       e_rd;
    logic [3:0] e_we;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl[12];

  // Reference model state (flags by control-bit position, T as remaining pulse cycles)
  logic [5:0] m_flags;
  int         m_tleft;
  logic [7:0] m_dout;
  logic       m_irq;
  logic       m_nmi;
  logic [1:0] n;
  logic [3:0] e_sel;
  logic [3:0] e_we;
  logic       e_rd;

  initial begin
    // cs addr rdnw din pdata dav nf | sel rd we dout   (flags all clear)
    tbl[0]  = '{1'b1, 3'd5, 1'b1, 8'h00, 8'h5A, 4'b0000, 4'b0000, 4'b0100, 1'b1, 4'b0000, 8'h5A};
    tbl[1]  = '{1'b1, 3'd7, 1'b0, 8'h3C, 8'h11, 4'b0000, 4'b0000, 4'b1000, 1'b0, 4'b1000, 8'h5A};
    tbl[2]  = '{1'b1, 3'd2, 1'b1, 8'h00, 8'h22, 4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0000, 8'hC0};
    tbl[3]  = '{1'b1, 3'd6, 1'b1, 8'h00, 8'h33, 4'b1000, 4'b0000, 4'b1000, 1'b0, 4'b0000, 8'h80};
    tbl[4]  = '{1'b1, 3'd0, 1'b1, 8'h00, 8'h44, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000, 8'hC0};
    tbl[5]  = '{1'b0, 3'd1, 1'b1, 8'h00, 8'h55, 4'b1111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 8'hC0};
    tbl[6]  = '{1'b1, 3'd1, 1'b1, 8'h00, 8'hA7, 4'b0000, 4'b0000, 4'b0001, 1'b1, 4'b0000, 8'hA7};
    tbl[7]  = '{1'b1, 3'd4, 1'b0, 8'hFF, 8'h66, 4'b0000, 4'b0000, 4'b0100, 1'b0, 4'b0000, 8'hA7};
    tbl[8]  = '{1'b1, 3'd0, 1'b1, 8'h00, 8'h77, 4'b0000, 4'b0000, 4'b0001, 1'b0, 4'b0000, 8'h00};
    tbl[9]  = '{1'b1, 3'd3, 1'b0, 8'h00, 8'h88, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 8'h00};
    tbl[10] = '{1'b1, 3'd6, 1'b1, 8'h00, 8'h99, 4'b0111, 4'b1000, 4'b1000, 1'b0, 4'b0000, 8'h40};
    tbl[11] = '{1'b0, 3'd7, 1'b0, 8'h55, 8'hAA, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h40};

    h_rst = 1'b1;
    h_cs = 1'b0; h_addr = 3'd0; h_rdnw = 1'b1; h_din = 8'h00;
    ph_data = 8'h00; ph_data_available = 4'b0000; hp_not_full = 4'b0000;
    ph_zero_bytes_available = 1'b1;
    tick();
    tick();
    h_rst = 1'b0;

    chk("rst_dout", 32'(h_dout), 32'h00);
    chk("rst_irq", 32'(h_irq_b), 32'h1);
    chk("rst_nmi", 32'(h_nmi_b), 32'h1);
    chk("rst_obm", 32'(one_byte_mode), 32'h0);
    chk("rst_prst", 32'(p_rst), 32'h0);
    chk("rst_clr", 32'(h_clr_fifos), 32'h0);

    // ---- table-driven decode / read mux vectors ----
    for (int i = 0; i < 12; i++) begin
      h_cs = tbl[i].cs; h_addr = tbl[i].addr; h_rdnw = tbl[i].rdnw; h_din = tbl[i].din;
      ph_data = tbl[i].pdata; ph_data_available = tbl[i].dav; hp_not_full = tbl[i].nf;
      #1;
      chk($sformatf("tbl%0d_sel", i), 32'(h_selectData), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_rd", i), 32'(h_rd), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_we", i), 32'(h_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_wdata", i), 32'(h_wdata), 32'(tbl[i].din));
      tick();
      h_cs = 1'b0;
      chk($sformatf("tbl%0d_dout", i), 32'(h_dout), 32'(tbl[i].e_dout));
    end
    ph_data_available = 4'b0000; hp_not_full = 4'b0000;

    // ---- asynchronous reset mid-cycle with P, V, J set ----
    acc(3'd0, 1'b0, 8'hB4);
    chk("pre_rst_prst", 32'(p_rst), 32'h1);
    chk("pre_rst_obm", 32'(one_byte_mode), 32'h1);
    ph_data_available = 4'b1000;
    tick();
    chk("pre_rst_irq", 32'(h_irq_b), 32'h0);
    ph_data = 8'h5A;
    acc(3'd5, 1'b1, 8'h00);
    chk("pre_rst_dout", 32'(h_dout), 32'h5A);
    h_cs = 1'b1; h_addr = 3'd3; h_rdnw = 1'b0;
    #2;
    h_rst = 1'b1;
    #1;
    chk("arst_dout", 32'(h_dout), 32'h00);
    chk("arst_irq", 32'(h_irq_b), 32'h1);
    chk("arst_nmi", 32'(h_nmi_b), 32'h1);
    chk("arst_prst", 32'(p_rst), 32'h0);
    chk("arst_obm", 32'(one_byte_mode), 32'h0);
    chk("arst_we_live", 32'(h_we), 32'b0010);
    h_cs = 1'b0;
    ph_data_available = 4'b0000;
    tick();
    h_rst = 1'b0;
    acc(3'd0, 1'b1, 8'h00);
    chk("arst_status", 32'(h_dout), 32'h00);

    // ---- flag set / clear ----
    acc(3'd0, 1'b0, 8'hB5);
    ph_data_available = 4'b0001; hp_not_full = 4'b0000;
    acc(3'd0, 1'b1, 8'h00);
    chk("flags_set", 32'(h_dout), 32'hB5);
    acc(3'd0, 1'b0, 8'h11);
    acc(3'd0, 1'b1, 8'h00);
    chk("flags_clr", 32'(h_dout), 32'hA4);

    // ---- T pulse ----
    chk("t_idle", 32'(h_clr_fifos), 32'h0);
    acc(3'd0, 1'b0, 8'hC0);
    chk("t_c1", 32'(h_clr_fifos), 32'h1);
    tick();
    chk("t_c2", 32'(h_clr_fifos), 32'h1);
    tick();
    chk("t_end", 32'(h_clr_fifos), 32'h0);
    acc(3'd0, 1'b1, 8'h00);
    chk("t_status", 32'(h_dout), 32'hA4);
    acc(3'd0, 1'b0, 8'hC0);
    acc(3'd0, 1'b0, 8'hC0);
    chk("t_reload_c1", 32'(h_clr_fifos), 32'h1);
    tick();
    chk("t_reload_c2", 32'(h_clr_fifos), 32'h1);
    tick();
    chk("t_reload_end", 32'(h_clr_fifos), 32'h0);
    acc(3'd0, 1'b0, 8'hC0);
    acc(3'd0, 1'b0, 8'h40);
    chk("t_clear", 32'(h_clr_fifos), 32'h0);

    // ---- interrupts (J and P set here) ----
    ph_data_available = 4'b1000;
    chk("irq_not_yet", 32'(h_irq_b), 32'h1);
    tick();
    chk("irq_low", 32'(h_irq_b), 32'h0);
    ph_data_available = 4'b0000;
    tick();
    chk("irq_high", 32'(h_irq_b), 32'h1);
    acc(3'd0, 1'b0, 8'h88);
    ph_zero_bytes_available = 1'b0;
    chk("nmi_not_yet", 32'(h_nmi_b), 32'h1);
    tick();
    chk("nmi_low", 32'(h_nmi_b), 32'h0);
    acc(3'd0, 1'b0, 8'h90);
    chk("nmi_v_k1", 32'(h_nmi_b), 32'h0);
    chk("obm_set", 32'(one_byte_mode), 32'h1);
    tick();
    chk("nmi_v_high", 32'(h_nmi_b), 32'h1);

    // ---- randomized run against the reference model ----
    h_rst = 1'b1;
    tick();
    h_rst = 1'b0;
    m_flags = 6'b000000; m_tleft = 0; m_dout = 8'h00; m_irq = 1'b1; m_nmi = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      h_cs    = ($urandom_range(0, 3) != 0);
      h_addr  = 3'($urandom_range(0, 7));
      h_rdnw  = 1'($urandom_range(0, 1));
      h_din   = 8'($urandom);
      ph_data = 8'($urandom);
      ph_data_available = 4'($urandom);
      hp_not_full = 4'($urandom);
      ph_zero_bytes_available = 1'($urandom_range(0, 1));
      #1;
      n = h_addr[2:1];
      e_sel = 4'b0000;
      e_we  = 4'b0000;
      if (h_cs) e_sel[n] = 1'b1;
      e_rd = h_cs && h_rdnw && h_addr[0];
      if (h_cs && !h_rdnw && h_addr[0]) e_we[n] = 1'b1;
      chk("rnd_sel", 32'(h_selectData), 32'(e_sel));
      chk("rnd_rd", 32'(h_rd), 32'(e_rd));
      chk("rnd_we", 32'(h_we), 32'(e_we));
      chk("rnd_wdata", 32'(h_wdata), 32'(h_din));
      chk("rnd_dout", 32'(h_dout), 32'(m_dout));
      chk("rnd_irq", 32'(h_irq_b), 32'(m_irq));
      chk("rnd_nmi", 32'(h_nmi_b), 32'(m_nmi));
      chk("rnd_obm", 32'(one_byte_mode), 32'(m_flags[4]));
      chk("rnd_prst", 32'(p_rst), 32'(m_flags[5]));
      chk("rnd_clr", 32'(h_clr_fifos), 32'(m_tleft > 0));

      // next state from the register rules, using pre-edge flags
      if (h_cs && h_rdnw) begin
        if (h_addr[0]) m_dout = ph_data;
        else m_dout = {ph_data_available[n], hp_not_full[n], (n == 2'd0) ? m_flags : 6'b000000};
      end
      m_irq = !(m_flags[2] && ph_data_available[3]);
      m_nmi = !(m_flags[3] && (m_flags[4] ? ph_data_available[2] : !ph_zero_bytes_available));
      if (m_tleft > 0) m_tleft = m_tleft - 1;
      if (h_cs && !h_rdnw && h_addr == 3'd0) begin
        for (int b = 0; b < 6; b++) if (h_din[b]) m_flags[b] = h_din[7];
        if (h_din[6]) m_tleft = h_din[7] ? T_LEN : 0;
      end
      tick();
    end
    h_cs = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
